// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: op encodings, RV32I opcodes, queue entry
// and decoded-field bundles.
package decode_queue_pkg;

    localparam int OP_W_DEF = 6;

    typedef enum logic [5:0] {
        OP_NOP   = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pd;
    } entry_t;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_use;
        logic        rs2_use;
        logic        rd_use;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/decode_core.sv
// Purely combinational RV32I decode of one instruction word into op, register
// names, operand-usage flags, immediate and an illegal flag.
module decode_core
    import decode_queue_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    op_e         op;
    logic [31:0] imm;
    logic        use1, use2, wr, bad;

    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        op   = OP_NOP;
        imm  = '0;
        use1 = 1'b0;
        use2 = 1'b0;
        wr   = 1'b0;
        bad  = 1'b0;
        case (inst[6:0])
            OPC_LUI:   begin op = OP_LUI;   imm = imm_u; wr = 1'b1; end
            OPC_AUIPC: begin op = OP_AUIPC; imm = imm_u; wr = 1'b1; end
            OPC_JAL:   begin op = OP_JAL;   imm = imm_j; wr = 1'b1; end
            OPC_JALR:  begin op = OP_JALR;  imm = imm_i; use1 = 1'b1; wr = 1'b1; end
            OPC_BRANCH: begin
                imm = imm_b; use1 = 1'b1; use2 = 1'b1;
                case (f3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                imm = imm_i; use1 = 1'b1; wr = 1'b1;
                case (f3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                imm = imm_s; use1 = 1'b1; use2 = 1'b1;
                case (f3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    default: bad = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                // inst[30] only matters for the shift forms
                imm = imm_i; use1 = 1'b1; wr = 1'b1;
                case (f3)
                    3'b000: op = OP_ADDI;
                    3'b010: op = OP_SLTI;
                    3'b011: op = OP_SLTIU;
                    3'b100: op = OP_XORI;
                    3'b110: op = OP_ORI;
                    3'b111: op = OP_ANDI;
                    3'b001: begin
                        if (f7 == F7_ZERO) op = OP_SLLI;
                        else               bad = 1'b1;
                    end
                    default: begin
                        if (f7 == F7_ZERO)     op = OP_SRLI;
                        else if (f7 == F7_ALT) op = OP_SRAI;
                        else                   bad = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                use1 = 1'b1; use2 = 1'b1; wr = 1'b1;
                if (f7 == F7_ZERO) begin
                    case (f3)
                        3'b000:  op = OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b011:  op = OP_SLTU;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = OP_SRL;
                        3'b110:  op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        3'b000:  op = OP_SUB;
                        3'b101:  op = OP_SRA;
                        default: bad = 1'b1;
                    endcase
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.rd      = inst[11:7];
        dec.illegal = bad;
        dec.op      = bad ? OP_NOP : op;
        dec.imm     = bad ? 32'd0 : imm;
        dec.rs1_use = use1 && !bad;
        dec.rs2_use = use2 && !bad;
        dec.rd_use  = wr && !bad && (inst[11:7] != 5'd0);
    end

endmodule

// File: rtl/decode_queue.sv
// Circular instruction queue between fetch and dispatch; the head entry is
// decoded combinationally and captured into a registered output stage.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = 2,
    parameter int OP_W     = OP_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            iROB_clr,
    input  logic            iINF_en,
    input  logic [31:0]     iINF_inst,
    input  logic [31:0]     iINF_pc,
    input  logic            iINF_pd,
    output logic            oINF_full,
    output logic            oINF_afull,
    input  logic            iDEC_stall,
    output logic            oDEC_en,
    output logic [OP_W-1:0] oDEC_op,
    output logic [4:0]      oDEC_rs1,
    output logic [4:0]      oDEC_rs2,
    output logic [4:0]      oDEC_rd,
    output logic            oDEC_rs1_use,
    output logic            oDEC_rs2_use,
    output logic            oDEC_rd_use,
    output logic [31:0]     oDEC_imm,
    output logic [31:0]     oDEC_pc,
    output logic            oDEC_pd,
    output logic            oDEC_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head_reg, tail_reg;
    logic [CNT_W-1:0]   count_reg;
    entry_t             head_entry;
    dec_t               head_dec;
    logic               wr_en, out_free, pop;

    assign oINF_full  = (count_reg == CNT_W'(DEPTH));
    assign oINF_afull = ((DEPTH - int'(count_reg)) <= AFULL_TH);

    assign wr_en    = iINF_en && !oINF_full;
    assign out_free = !oDEC_en || !iDEC_stall;
    assign pop      = (count_reg != '0) && out_free;

    assign head_entry = mem[head_reg];

    decode_core u_core (
        .inst (head_entry.inst),
        .dec  (head_dec)
    );

    // Storage carries no reset; validity lives entirely in count_reg.
    always_ff @(posedge clk) begin
        if (rdy && !iROB_clr && wr_en)
            mem[tail_reg] <= '{inst: iINF_inst, pc: iINF_pc, pd: iINF_pd};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (rdy) begin
            if (iROB_clr) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (wr_en) tail_reg <= tail_reg + PTR_W'(1);
                if (pop)   head_reg <= head_reg + PTR_W'(1);
                case ({wr_en, pop})
                    2'b10:   count_reg <= count_reg + CNT_W'(1);
                    2'b01:   count_reg <= count_reg - CNT_W'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oDEC_en      <= 1'b0;
            oDEC_op      <= OP_W'(OP_NOP);
            oDEC_rs1     <= '0;
            oDEC_rs2     <= '0;
            oDEC_rd      <= '0;
            oDEC_rs1_use <= 1'b0;
            oDEC_rs2_use <= 1'b0;
            oDEC_rd_use  <= 1'b0;
            oDEC_imm     <= '0;
            oDEC_pc      <= '0;
            oDEC_pd      <= 1'b0;
            oDEC_illegal <= 1'b0;
        end else if (rdy) begin
            if (iROB_clr) begin
                oDEC_en <= 1'b0;
            end else if (pop) begin
                oDEC_en      <= 1'b1;
                oDEC_op      <= OP_W'(head_dec.op);
                oDEC_rs1     <= head_dec.rs1;
                oDEC_rs2     <= head_dec.rs2;
                oDEC_rd      <= head_dec.rd;
                oDEC_rs1_use <= head_dec.rs1_use;
                oDEC_rs2_use <= head_dec.rs2_use;
                oDEC_rd_use  <= head_dec.rd_use;
                oDEC_imm     <= head_dec.imm;
                oDEC_pc      <= head_entry.pc;
                oDEC_pd      <= head_entry.pd;
                oDEC_illegal <= head_dec.illegal;
            end else if (out_free) begin
                oDEC_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=4, AFULL_TH=1): decode fields, fill and
// backpressure, wrap-around streaming, flush, rdy hold and asynchronous reset.
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        iROB_clr = 1'b0;
    logic        iINF_en = 1'b0;
    logic [31:0] iINF_inst = '0;
    logic [31:0] iINF_pc = '0;
    logic        iINF_pd = 1'b0;
    logic        iDEC_stall = 1'b0;
    logic        oINF_full, oINF_afull, oDEC_en;
    logic [5:0]  oDEC_op;
    logic [4:0]  oDEC_rs1, oDEC_rs2, oDEC_rd;
    logic        oDEC_rs1_use, oDEC_rs2_use, oDEC_rd_use;
    logic [31:0] oDEC_imm, oDEC_pc;
    logic        oDEC_pd, oDEC_illegal;

    int n_vec = 0;
    int n_err = 0;

    decode_queue #(.DEPTH(4), .AFULL_TH(1), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .iROB_clr(iROB_clr),
        .iINF_en(iINF_en), .iINF_inst(iINF_inst), .iINF_pc(iINF_pc), .iINF_pd(iINF_pd),
        .oINF_full(oINF_full), .oINF_afull(oINF_afull), .iDEC_stall(iDEC_stall),
        .oDEC_en(oDEC_en), .oDEC_op(oDEC_op), .oDEC_rs1(oDEC_rs1), .oDEC_rs2(oDEC_rs2),
        .oDEC_rd(oDEC_rd), .oDEC_rs1_use(oDEC_rs1_use), .oDEC_rs2_use(oDEC_rs2_use),
        .oDEC_rd_use(oDEC_rd_use), .oDEC_imm(oDEC_imm), .oDEC_pc(oDEC_pc),
        .oDEC_pd(oDEC_pd), .oDEC_illegal(oDEC_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one instruction for exactly one edge.
    task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic pd);
        iINF_en   = 1'b1;
        iINF_inst = inst;
        iINF_pc   = pc;
        iINF_pd   = pd;
        step();
        iINF_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        n_vec++;
        if ({oDEC_en, oINF_full, oINF_afull, oDEC_illegal, oDEC_pd} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000",
                     {oDEC_en, oINF_full, oINF_afull, oDEC_illegal, oDEC_pd});
        end
        n_vec++;
        if ({oDEC_op, oDEC_imm, oDEC_pc} !== {6'(OP_NOP), 64'h0}) begin
            n_err++;
            $display("FAIL reset_data: got op=%0d imm=%h pc=%h want op=%0d imm=0 pc=0",
                     oDEC_op, oDEC_imm, oDEC_pc, OP_NOP);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_decode();
        logic [31:0] t_inst [9];
        op_e         t_op   [9];
        logic [14:0] t_regs [9];   // {rs1, rs2, rd}
        logic [31:0] t_imm  [9];
        logic [3:0]  t_flg  [9];   // {rs1_use, rs2_use, rd_use, illegal}
        t_inst[0] = 32'h00500093; t_op[0] = OP_ADDI;  t_regs[0] = {5'd0, 5'd5, 5'd1};  t_imm[0] = 32'h5;        t_flg[0] = 4'b1010;
        t_inst[1] = 32'h123450B7; t_op[1] = OP_LUI;   t_regs[1] = {5'd8, 5'd3, 5'd1};  t_imm[1] = 32'h12345000; t_flg[1] = 4'b0010;
        t_inst[2] = 32'hFE208EE3; t_op[2] = OP_BEQ;   t_regs[2] = {5'd1, 5'd2, 5'd29}; t_imm[2] = 32'hFFFFFFFC; t_flg[2] = 4'b1100;
        t_inst[3] = 32'h0000007F; t_op[3] = OP_NOP;   t_regs[3] = {5'd0, 5'd0, 5'd0};  t_imm[3] = 32'h0;        t_flg[3] = 4'b0001;
        t_inst[4] = 32'h00000013; t_op[4] = OP_ADDI;  t_regs[4] = {5'd0, 5'd0, 5'd0};  t_imm[4] = 32'h0;        t_flg[4] = 4'b1000;
        t_inst[5] = 32'h00112223; t_op[5] = OP_SW;    t_regs[5] = {5'd2, 5'd1, 5'd4};  t_imm[5] = 32'h4;        t_flg[5] = 4'b1100;
        t_inst[6] = 32'h40209033; t_op[6] = OP_NOP;   t_regs[6] = {5'd1, 5'd2, 5'd0};  t_imm[6] = 32'h0;        t_flg[6] = 4'b0001;
        t_inst[7] = 32'h4030D093; t_op[7] = OP_SRAI;  t_regs[7] = {5'd1, 5'd3, 5'd1};  t_imm[7] = 32'h403;      t_flg[7] = 4'b1010;
        t_inst[8] = 32'h00013083; t_op[8] = OP_NOP;   t_regs[8] = {5'd2, 5'd0, 5'd1};  t_imm[8] = 32'h0;        t_flg[8] = 4'b0001;
        iDEC_stall = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push(t_inst[i], 32'h1000 + 32'(i * 4), i[0]);
            step();
            $display("decode pc=%h inst=%h op=%0d imm=%h illegal=%b",
                     oDEC_pc, t_inst[i], oDEC_op, oDEC_imm, oDEC_illegal);
            n_vec++;
            if ({oDEC_en, oDEC_pc, oDEC_pd} !== {1'b1, 32'h1000 + 32'(i * 4), i[0]}) begin
                n_err++;
                $display("FAIL dec%0d_valid: got en=%b pc=%h pd=%b want en=1 pc=%h pd=%b",
                         i, oDEC_en, oDEC_pc, oDEC_pd, 32'h1000 + 32'(i * 4), i[0]);
            end
            n_vec++;
            if (oDEC_op !== 6'(t_op[i])) begin
                n_err++;
                $display("FAIL dec%0d_op: got %0d want %0d", i, oDEC_op, t_op[i]);
            end
            n_vec++;
            if ({oDEC_rs1, oDEC_rs2, oDEC_rd} !== t_regs[i]) begin
                n_err++;
                $display("FAIL dec%0d_regs: got rs1=%0d rs2=%0d rd=%0d want %0d %0d %0d",
                         i, oDEC_rs1, oDEC_rs2, oDEC_rd, t_regs[i][14:10], t_regs[i][9:5], t_regs[i][4:0]);
            end
            n_vec++;
            if (oDEC_imm !== t_imm[i]) begin
                n_err++;
                $display("FAIL dec%0d_imm: got %h want %h", i, oDEC_imm, t_imm[i]);
            end
            n_vec++;
            if ({oDEC_rs1_use, oDEC_rs2_use, oDEC_rd_use, oDEC_illegal} !== t_flg[i]) begin
                n_err++;
                $display("FAIL dec%0d_flags: got %b want %b", i,
                         {oDEC_rs1_use, oDEC_rs2_use, oDEC_rd_use, oDEC_illegal}, t_flg[i]);
            end
        end
        step();
    endtask

    task automatic test_fill();
        logic [1:0] exp_fa [6];   // {full, afull} after each push edge
        logic       exp_en [6];
        exp_fa[0] = 2'b00; exp_en[0] = 1'b0;
        exp_fa[1] = 2'b00; exp_en[1] = 1'b1;
        exp_fa[2] = 2'b00; exp_en[2] = 1'b1;
        exp_fa[3] = 2'b01; exp_en[3] = 1'b1;
        exp_fa[4] = 2'b11; exp_en[4] = 1'b1;
        exp_fa[5] = 2'b11; exp_en[5] = 1'b1;
        iDEC_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(32'h00000013, 32'h200 + 32'(i * 4), 1'b0);
            $display("fill push=%0d full=%b afull=%b out_en=%b", i, oINF_full, oINF_afull, oDEC_en);
            n_vec++;
            if ({oINF_full, oINF_afull, oDEC_en} !== {exp_fa[i], exp_en[i]}) begin
                n_err++;
                $display("FAIL fill%0d_flags: got full/afull/en=%b want %b",
                         i, {oINF_full, oINF_afull, oDEC_en}, {exp_fa[i], exp_en[i]});
            end
            if (i >= 1) begin
                n_vec++;
                if (oDEC_pc !== 32'h200) begin
                    n_err++;
                    $display("FAIL fill%0d_hold: got pc=%h want 00000200", i, oDEC_pc);
                end
            end
        end
        iDEC_stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            $display("drain out pc=%h en=%b", oDEC_pc, oDEC_en);
            n_vec++;
            if ({oDEC_en, oDEC_pc} !== {1'b1, 32'h200 + 32'(k * 4)}) begin
                n_err++;
                $display("FAIL drain%0d: got en=%b pc=%h want en=1 pc=%h",
                         k, oDEC_en, oDEC_pc, 32'h200 + 32'(k * 4));
            end
        end
        step();
        n_vec++;
        if ({oDEC_en, oINF_full, oINF_afull} !== 3'b000) begin
            n_err++;
            $display("FAIL drain_empty: got en/full/afull=%b want 000", {oDEC_en, oINF_full, oINF_afull});
        end
    endtask

    task automatic test_wrap();
        int  sent = 0;
        int  got  = 0;
        bit  acc;
        iINF_inst = 32'h00000013;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            iINF_en    = (sent < 20);
            iINF_pc    = 32'(sent * 4);
            iDEC_stall = 1'($urandom_range(0, 1));
            acc = iINF_en && !oINF_full;
            if (oDEC_en && !iDEC_stall) begin
                $display("wrap out pc=%h", oDEC_pc);
                n_vec++;
                if (oDEC_pc !== 32'(got * 4)) begin
                    n_err++;
                    $display("FAIL wrap_pc%0d: got %h want %h", got, oDEC_pc, 32'(got * 4));
                end
                got++;
            end
            step();
            if (acc) sent++;
        end
        iINF_en    = 1'b0;
        iDEC_stall = 1'b0;
        n_vec++;
        if (got != 20) begin
            n_err++;
            $display("FAIL wrap_count: got %0d outputs want 20", got);
        end
        step();
        step();
        n_vec++;
        if (oDEC_en !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_extra: got en=%b pc=%h want en=0", oDEC_en, oDEC_pc);
        end
    endtask

    task automatic test_flush();
        iDEC_stall = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h00000013, 32'h300 + 32'(i * 4), 1'b0);
        n_vec++;
        if ({oDEC_en, oDEC_pc, oINF_afull} !== {1'b1, 32'h300, 1'b1}) begin
            n_err++;
            $display("FAIL flush_setup: got en=%b pc=%h afull=%b want en=1 pc=00000300 afull=1",
                     oDEC_en, oDEC_pc, oINF_afull);
        end
        iROB_clr = 1'b1;
        push(32'h00000013, 32'h3F0, 1'b0);
        iROB_clr = 1'b0;
        $display("flush en=%b full=%b afull=%b", oDEC_en, oINF_full, oINF_afull);
        n_vec++;
        if ({oDEC_en, oINF_full, oINF_afull} !== 3'b000) begin
            n_err++;
            $display("FAIL flush_clear: got en/full/afull=%b want 000", {oDEC_en, oINF_full, oINF_afull});
        end
        iDEC_stall = 1'b0;
        step();
        step();
        n_vec++;
        if (oDEC_en !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ghost: got en=%b pc=%h want en=0", oDEC_en, oDEC_pc);
        end
        push(32'h123450B7, 32'h400, 1'b1);
        step();
        n_vec++;
        if ({oDEC_en, oDEC_pc, oDEC_op, oDEC_pd} !== {1'b1, 32'h400, 6'(OP_LUI), 1'b1}) begin
            n_err++;
            $display("FAIL flush_next: got en=%b pc=%h op=%0d pd=%b want en=1 pc=00000400 op=%0d pd=1",
                     oDEC_en, oDEC_pc, oDEC_op, oDEC_pd, OP_LUI);
        end
        step();
        n_vec++;
        if (oDEC_en !== 1'b0) begin
            n_err++;
            $display("FAIL flush_after: got en=%b pc=%h want en=0", oDEC_en, oDEC_pc);
        end
    endtask

    task automatic test_rdy();
        iDEC_stall = 1'b1;
        push(32'h00000013, 32'h500, 1'b0);
        push(32'h00000013, 32'h504, 1'b0);
        rdy        = 1'b0;
        iINF_en    = 1'b1;
        iINF_pc    = 32'h508;
        iDEC_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            $display("rdy_low cycle=%0d en=%b pc=%h", i, oDEC_en, oDEC_pc);
            n_vec++;
            if ({oDEC_en, oDEC_pc, oINF_full, oINF_afull} !== {1'b1, 32'h500, 2'b00}) begin
                n_err++;
                $display("FAIL rdy_hold%0d: got en=%b pc=%h full=%b afull=%b want en=1 pc=00000500 full=0 afull=0",
                         i, oDEC_en, oDEC_pc, oINF_full, oINF_afull);
            end
        end
        iINF_en = 1'b0;
        rdy     = 1'b1;
        step();
        n_vec++;
        if ({oDEC_en, oDEC_pc} !== {1'b1, 32'h504}) begin
            n_err++;
            $display("FAIL rdy_resume: got en=%b pc=%h want en=1 pc=00000504", oDEC_en, oDEC_pc);
        end
        step();
        n_vec++;
        if (oDEC_en !== 1'b0) begin
            n_err++;
            $display("FAIL rdy_nowrite: got en=%b pc=%h want en=0", oDEC_en, oDEC_pc);
        end
    endtask

    task automatic test_async_reset();
        iDEC_stall = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h123450B7, 32'h600 + 32'(i * 4), 1'b1);
        #2;
        rst = 1'b0;
        #1;
        $display("async_reset en=%b op=%0d pc=%h", oDEC_en, oDEC_op, oDEC_pc);
        n_vec++;
        if ({oDEC_en, oDEC_pd, oDEC_rd_use, oINF_afull} !== 4'b0000) begin
            n_err++;
            $display("FAIL areset_flags: got en/pd/rd_use/afull=%b want 0000",
                     {oDEC_en, oDEC_pd, oDEC_rd_use, oINF_afull});
        end
        n_vec++;
        if ({oDEC_op, oDEC_imm, oDEC_pc, oDEC_rd} !== {6'(OP_NOP), 64'h0, 5'd0}) begin
            n_err++;
            $display("FAIL areset_data: got op=%0d imm=%h pc=%h rd=%0d want op=%0d imm=0 pc=0 rd=0",
                     oDEC_op, oDEC_imm, oDEC_pc, oDEC_rd, OP_NOP);
        end
        step();
        rst        = 1'b1;
        iDEC_stall = 1'b0;
        step();
        step();
        n_vec++;
        if (oDEC_en !== 1'b0) begin
            n_err++;
            $display("FAIL areset_lost: got en=%b pc=%h want en=0", oDEC_en, oDEC_pc);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_fill();
        test_wrap();
        test_flush();
        test_rdy();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
